// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types and register-map addresses
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_master_state_e;

  // Register-map offsets common to the register blocks and their benches
  localparam logic [7:0] APB_ADDR_STATUS  = 8'h00;
  localparam logic [7:0] APB_ADDR_CONTROL = 8'h04;
  localparam logic [7:0] APB_ADDR_DATA    = 8'h08;
  localparam logic [7:0] APB_ADDR_CONFIG  = 8'h0C;

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - saturating ACCESS wait-state counter with expiry flag
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] LIMIT = CW'(LIM);
  localparam logic [CW-1:0] MAX   = '1;

  logic [CW-1:0] count;

  // Count stalled ACCESS cycles; hold at all-ones rather than wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  // The cycle at count == TIMEOUT_CYCLES-1 is the last ACCESS cycle allowed
  assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command to APB requester bridge with timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_master_state_e state;
  logic              tmo_expired;

  // Only IDLE accepts work; everything else drops cmd_valid on the floor
  assign cmd_ready = (state == IDLE);

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == SETUP),
    .enable ((state == ACCESS) && !pready),
    .expired(tmo_expired)
  );

  // Transfer sequencer; every APB and response output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A completer answer in the last allowed cycle wins over the timeout
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (tmo_expired) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Completer storage and the bench's own expectation of register contents
  logic [31:0] slv_mem [256];
  logic [31:0] ref_mem [256];

  apb_master_bridge #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full command: completer answers after 'waits' stalled ACCESS cycles
  task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                      input int waits, input logic serr, input int stall, input logic hold_valid);
    int          lat;
    int          acc;
    int          acc_exp;
    bit          ok;
    logic        exp_to;
    logic        exp_err;
    logic [31:0] exp_rd;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    @(posedge clk);
    #1;
    if (!hold_valid) cmd_valid = 1'b0;
    lat = 0;
    acc = 0;
    ok  = 1'b1;
    @(negedge clk);
    while (!rsp_valid && lat < 60) begin
      if (cmd_ready !== 1'b0 || psel !== 1'b1) ok = 1'b0;
      if (paddr !== a || pwrite !== w || pwdata !== d) ok = 1'b0;
      if (lat == 0) begin
        if (penable !== 1'b0) ok = 1'b0;
      end else begin
        if (penable !== 1'b1) ok = 1'b0;
        pready  = (acc == waits);
        pslverr = pready & serr;
        prdata  = pready ? slv_mem[a] : $urandom;
        acc++;
      end
      @(posedge clk);
      lat++;
      if (pready && w && !serr) slv_mem[a] = d;
      #1;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
      @(negedge clk);
    end
    exp_to  = (waits >= TMO);
    acc_exp = exp_to ? TMO : waits + 1;
    exp_err = exp_to | serr;
    exp_rd  = (exp_to || w) ? 32'h0 : ref_mem[a];
    if (w && !exp_err) ref_mem[a] = d;
    chk("protocol", ok, 1'b1);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("latency", lat, 1 + acc_exp);
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", rsp_err, exp_err);
    chk("timeout", rsp_timeout, exp_to);
    chk("psel_resp", {psel, penable}, 2'b00);
    rsp_ready = 1'b0;
    ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_err ||
          rsp_timeout !== exp_to || psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b0)
        ok = 1'b0;
    end
    if (stall > 0) chk("resp_hold", ok, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    logic [7:0]  ra;
    int          wt;
    logic        rw;
    logic        re;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end

    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_apb_ctl", {psel, penable, pwrite}, 3'b000);
    chk("rst_paddr", paddr, 8'h00);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    xfer(APB_ADDR_CONTROL, 1'b1, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0);
    xfer(APB_ADDR_CONTROL, 1'b0, 32'h0000_0000, 0, 1'b0, 0, 1'b0);
    xfer(APB_ADDR_DATA,    1'b1, 32'h12345678, 0, 1'b0, 1, 1'b0);
    xfer(APB_ADDR_DATA,    1'b0, 32'hA5A5A5A5, 5, 1'b0, 0, 1'b0);
    xfer(APB_ADDR_CONFIG,  1'b0, 32'h0,        100, 1'b0, 0, 1'b0);
    xfer(APB_ADDR_DATA,    1'b0, 32'h0,        TMO - 1, 1'b0, 0, 1'b0);
    xfer(APB_ADDR_STATUS,  1'b1, 32'h0BADF00D, 0, 1'b1, 10, 1'b1);
    xfer(APB_ADDR_STATUS,  1'b1, 32'h600DCAFE, 0, 1'b0, 0, 1'b0);

    // Asynchronous reset while the completer is stalling in ACCESS
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = APB_ADDR_DATA;
    cmd_write = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_access", {psel, penable}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_apb", {psel, penable}, 2'b00);
    chk("async_rst_rsp", rsp_valid, 1'b0);
    chk("async_rst_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(APB_ADDR_CONTROL, 1'b0, 32'h0, 2, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: ra = APB_ADDR_STATUS;
        1: ra = APB_ADDR_CONTROL;
        2: ra = APB_ADDR_DATA;
        3: ra = APB_ADDR_CONFIG;
        default: ra = 8'($urandom);
      endcase
      wt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 4)) : int'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 7) == 0);
      xfer(ra, rw, $urandom, wt, re, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
